// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the mode-selectable circular buffer.
package fifo_pkg;

    // Queue discipline encodings, also the encoding of the mode register.
    localparam logic MODE_FIFO = 1'b0;
    localparam logic MODE_LIFO = 1'b1;

    // Occupancy needs one bit more than a pointer so that "full" (DEPTH) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; occupancy tracking decides what is valid.
module fifo_mem #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on a write-enable cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_mode_buf.sv
// Pointer-based circular buffer whose discipline (FIFO or LIFO) is chosen at run time.
// Entries never move; only the pointers and the occupancy count change.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// in_ready depends only on count (no pass-through while full) and out_valid only on
// count, so neither ready nor valid ever depends combinationally on the other side;
// a producer may hold in_valid/in_data across cycles until a push occurs.
module fifo_mode_buf
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clr_err,
    output logic                    mode_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic          mode_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] top_ptr;
    logic          push;
    logic          pop;
    logic          mode_take;
    logic          mem_we;
    logic [PW-1:0] mem_waddr;
    logic [PW-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_d;
    logic [CW-1:0] count_d;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // The discipline may only change while the buffer is empty and nothing is arriving.
    assign mode_take = (count == '0) && !push;

    // LIFO top of stack is the slot just below the write pointer (wraps modulo DEPTH).
    assign top_ptr = wr_ptr - PW'(1);

    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));
    assign mode_state   = mode_q;

    // Select write/read addresses: a LIFO push+pop replaces the current top in place.
    always_comb begin
        mem_we    = push;
        mem_waddr = wr_ptr;
        mem_raddr = rd_ptr;
        if (mode_q == MODE_LIFO) begin
            mem_raddr = top_ptr;
            if (push && pop) begin
                mem_waddr = top_ptr;
            end
        end
    end

    // Next pointer and count values for the active discipline.
    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        count_d  = count;
        if (push && !pop) begin
            count_d = count + CW'(1);
        end else if (pop && !push) begin
            count_d = count - CW'(1);
        end
        if (mode_q == MODE_FIFO) begin
            if (push) wr_ptr_d = wr_ptr + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr + PW'(1);
        end else begin
            if (push && !pop)      wr_ptr_d = wr_ptr + PW'(1);
            else if (pop && !push) wr_ptr_d = wr_ptr - PW'(1);
        end
        if (mode_take) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // Register pointers, count and discipline; reset discards every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mode_q <= MODE_FIFO;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            count  <= count_d;
            if (mode_take) begin
                mode_q <= mode;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (in_valid && !in_ready) overflow <= 1'b1;
            else if (clr_err)          overflow <= 1'b0;
            if (out_ready && !out_valid) underflow <= 1'b1;
            else if (clr_err)            underflow <= 1'b0;
        end
    end

    fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (PW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (in_data),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign out_data = out_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_fifo_mode_buf.sv
// Directed bench for fifo_mode_buf with default parameters (DEPTH 16, AF 14, AE 2).
module tb_fifo_mode_buf;

    logic       clk;
    logic       reset;
    logic       mode;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [4:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;
    logic       clr_err;
    logic       mode_state;

    int checks;
    int errors;
    int exp_cnt;
    logic [7:0] exp_q[$];

    fifo_mode_buf dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err),
        .mode_state   (mode_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // advance one edge; inputs change and outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_levels(input string tag);
        check({tag, "_count"}, 32'(count), 32'(exp_cnt));
        check({tag, "_af"}, 32'(almost_full), 32'(exp_cnt >= 14));
        check({tag, "_ae"}, 32'(almost_empty), 32'(exp_cnt <= 2));
        check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_cnt != 16));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(exp_cnt != 0));
    endtask

    // driver: single push, model count follows
    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        exp_cnt++;
    endtask

    // driver: check the visible entry then pop it
    task automatic pop_expect(input string tag, input logic [7:0] d);
        check({tag, "_data"}, 32'(out_data), 32'(d));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt--;
    endtask

    task automatic fifo_push(input logic [7:0] d);
        exp_q.push_back(d);
        push(d);
    endtask

    task automatic fifo_pop(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        pop_expect(tag, e);
        check_levels(tag);
    endtask

    initial begin
        checks = 0; errors = 0; exp_cnt = 0;
        reset = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; clr_err = 1'b0;
        step(); step();
        reset = 1'b0;

        // reset state
        check_levels("rst");
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_unf", 32'(underflow), 32'h0);
        check("rst_mode", 32'(mode_state), 32'h0);
        step();

        // FIFO basic order
        fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33);
        check_levels("f3");
        fifo_pop("fpop1"); fifo_pop("fpop2"); fifo_pop("fpop3");
        check("f_empty_data", 32'(out_data), 32'h0);

        // FIFO fill, overflow, wrap
        for (int i = 0; i < 16; i++) begin
            fifo_push(8'(8'h40 + i));
            check_levels("fill");
        end
        in_valid = 1'b1; in_data = 8'hEE;
        step();
        in_valid = 1'b0;
        check("ovf_set", 32'(overflow), 32'h1);
        check_levels("ovf");
        for (int i = 0; i < 10; i++) fifo_pop("wpop_a");
        for (int i = 0; i < 10; i++) begin
            fifo_push(8'(8'h60 + i));
            check_levels("wpush");
        end
        for (int i = 0; i < 16; i++) fifo_pop("wpop_b");
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("ovf_clr", 32'(overflow), 32'h0);

        // LIFO with simultaneous push+pop
        mode = 1'b1; step();
        check("lifo_mode", 32'(mode_state), 32'h1);
        push(8'hA1); push(8'hA2); push(8'hA3);
        check_levels("l3");
        check("l_top", 32'(out_data), 32'hA3);
        in_valid = 1'b1; in_data = 8'hB0; out_ready = 1'b1;
        check("l_pp_popped", 32'(out_data), 32'hA3);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check_levels("l_pp");
        pop_expect("lpop1", 8'hB0);
        pop_expect("lpop2", 8'hA2);
        pop_expect("lpop3", 8'hA1);
        check_levels("l_empty");

        // mode request ignored while non-empty
        mode = 1'b0; step();
        check("fifo_back", 32'(mode_state), 32'h0);
        fifo_push(8'h01); fifo_push(8'h02);
        mode = 1'b1; step();
        check("mode_ignored", 32'(mode_state), 32'h0);
        mode = 1'b0;
        fifo_pop("ipop1"); fifo_pop("ipop2");

        // underflow and clr_err interactions
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("unf_set", 32'(underflow), 32'h1);
        clr_err = 1'b1; step();
        check("unf_clr", 32'(underflow), 32'h0);
        check("ovf_clr2", 32'(overflow), 32'h0);
        step();
        check("clr_noerr", 32'(underflow), 32'h0);
        out_ready = 1'b1; step(); out_ready = 1'b0; clr_err = 1'b0;
        check("unf_wins", 32'(underflow), 32'h1);

        // reset mid-stream in LIFO mode
        mode = 1'b1; step();
        check("pre_rst_mode", 32'(mode_state), 32'h1);
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
        check_levels("pre_rst");
        mode = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        exp_cnt = 0;
        check_levels("mid_rst");
        check("mid_rst_mode", 32'(mode_state), 32'h0);
        check("mid_rst_unf", 32'(underflow), 32'h0);
        check("mid_rst_data", 32'(out_data), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_mode_buf.md
Name: fifo_mode_buf

Overview:
- Parametrised circular-buffer queue with a run-time selectable discipline: FIFO or LIFO.
- Uses valid/ready handshakes on both sides, show-ahead output, occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Next-generation storage element for datapath buffering. Replaces shift-register buffers: pointer-based storage, no data movement per push.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 2.
- DATA_WIDTH, 8, entry width in bits.
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- mode  in  1  requested discipline: 0 = FIFO, 1 = LIFO.
- in_valid  in  1  producer has data.
- in_data  in  DATA_WIDTH  write data.
- in_ready  out  1  buffer can accept data.
- out_valid  out  1  buffer holds data.
- out_data  out  DATA_WIDTH  head entry (FIFO) or top entry (LIFO).
- out_ready  in  1  consumer takes data.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- overflow  out  1  sticky; push attempted while full.
- underflow  out  1  sticky; pop attempted while empty.
- clr_err  in  1  clears overflow/underflow.

Behaviour:
- Reset (synchronous, wins over all inputs):
  - count=0, wr_ptr=0, rd_ptr=0, mode_q=FIFO, overflow=0, underflow=0.
  - Resulting outputs: in_ready=1, out_valid=0, out_data=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all entries.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != DEPTH), combinational from count only; no pass-through while full, even with a simultaneous pop.
  - out_valid = (count != 0).
  - A producer may hold in_valid across cycles; data is consumed only on a push cycle.
- Output:
  - out_data is combinational from storage.
  - FIFO: mem[rd_ptr]. LIFO: mem[wr_ptr-1] (modulo DEPTH).
  - out_data is forced to 0 when out_valid=0.
  - Push-to-visible latency is 1 cycle: data written at edge N appears on out_data after edge N.
- FIFO mode:
  - push writes mem[wr_ptr] and increments wr_ptr.
  - pop increments rd_ptr.
  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
- LIFO mode:
  - push writes mem[wr_ptr] and increments wr_ptr.
  - pop decrements wr_ptr. rd_ptr is unused and held.
  - Simultaneous push+pop: the current top is popped, in_data overwrites slot wr_ptr-1, wr_ptr is unchanged.
- Count:
  - +1 on push only, -1 on pop only.
  - Unchanged on push+pop or when idle.
  - Simultaneous push+pop when empty: only the push occurs, because out_valid=0.
- Mode switching:
  - mode is sampled into mode_q only on a cycle where count==0 and no push occurs.
  - Requests while non-empty are ignored.
  - On an accepted switch, both pointers are reset to 0.
- Error flags:
  - overflow sets on in_valid & !in_ready.
  - underflow sets on out_ready & !out_valid.
  - Both hold until clr_err or reset.
  - A set condition in the same cycle as clr_err wins; the flag stays 1.
- Threshold flags are combinational from registered count.

Decomposition:
- Package fifo_pkg:
  - MODE_FIFO=1'b0 and MODE_LIFO=1'b1 localparams.
  - Function for count width ($clog2(DEPTH)+1).
- Sub-module fifo_mem:
  - DEPTH x DATA_WIDTH register array.
  - One synchronous write port (we, waddr, wdata), one combinational read port (raddr, rdata), no reset.
- Control, pointers, count and flags stay in fifo_mode_buf.

Test Plan:
- Reset then idle -> count=0, in_ready=1, out_valid=0, out_data=0, almost_empty=1, overflow=0, underflow=0.
- FIFO: push 0x11,0x22,0x33 on consecutive cycles, then pop 3 -> out_data sequence 0x11,0x22,0x33; count 3 -> 0; out_valid drops after the third pop.
- FIFO wrap: push 16, pop 10, push 10 (DEPTH=16) -> in_ready=0 at count=16; a 17th push with in_valid sets overflow=1; data order preserved across the pointer wrap; almost_full=1 while count>=14.
- LIFO: set mode=1 while empty, push 0xA1,0xA2,0xA3, then push 0xB0 with a simultaneous pop -> popped value 0xA3, top becomes 0xB0, count stays 3; following pops yield 0xB0,0xA2,0xA1.
- Mode request mode=1 while count=2 in FIFO -> ignored, FIFO order continues; pop while empty sets underflow=1; clr_err with no error -> flags 0; clr_err in the same cycle as a new underflow -> underflow stays 1.
- Reset asserted with count=5 mid-stream -> next cycle count=0, out_valid=0, mode_q=FIFO, flags cleared.
